colour_mode_ctrl: RTL and testbench



---
 rtl/colour_mode_ctrl.sv | 170 +++++++++++++++++
 tb/tb_colour_mode_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/colour_mode_ctrl.sv
// colour_mode_ctrl
//   Button-driven mode controller for the colour_change datapath. The four
//   board buttons are synchronised and debounced. Presses edit a pending
//   colour mode. The pending mode is committed to o_mode only on a vsync
//   rising edge, so a frame is never split between two modes. An optional
//   auto-cycle mode steps the colour mode every AUTO_FRAMES frames.
//
// Ports
//   clk           : pixel clock
//   n_rst         : asynchronous active-low reset
//   btn[3:0]      : raw asynchronous push buttons, active-high
//                   [0] next mode, [1] previous mode, [2] passthrough,
//                   [3] toggle auto-cycle
//   i_vid_vsync   : vsync from the video timing
//   o_mode        : committed colour mode
//   o_mode_update : one-cycle pulse in the first cycle o_mode shows a new value
//   o_auto        : auto-cycle enabled
//   o_pending     : pending mode, committed on the next vsync rise
module colour_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int NUM_MODES       = 6,
  parameter int MODE_W          = 3,
  parameter int AUTO_FRAMES     = 60
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [3:0]        btn,
  input  logic              i_vid_vsync,
  output logic [MODE_W-1:0] o_mode,
  output logic              o_mode_update,
  output logic              o_auto,
  output logic [MODE_W-1:0] o_pending
);

  localparam int FRM_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [CNT_W-1:0]  DB_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);
  localparam logic [FRM_W-1:0]  FRM_MAX  = FRM_W'(AUTO_FRAMES - 1);

  // Wrapping is done by explicit compare so NUM_MODES need not be a power of 2.
  function automatic logic [MODE_W-1:0] mode_next(input logic [MODE_W-1:0] m);
    if (m == MODE_MAX) return {MODE_W{1'b0}};
    else               return m + {{(MODE_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [MODE_W-1:0] mode_prev(input logic [MODE_W-1:0] m);
    if (m == {MODE_W{1'b0}}) return MODE_MAX;
    else                     return m - {{(MODE_W-1){1'b0}}, 1'b1};
  endfunction

  logic [3:0]        sync1_q, sync2_q;
  logic [3:0]        stable_q, stable_d, stable_prev_q;
  logic [CNT_W-1:0]  db_cnt_q [4];
  logic [CNT_W-1:0]  db_cnt_d [4];
  logic              vsync_q;
  logic [MODE_W-1:0] pending_q, pending_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              update_q, update_d;
  logic              auto_q, auto_d;
  logic [FRM_W-1:0]  frm_q, frm_d;

  logic [3:0] press_s;
  logic       any_press_s;
  logic       vsync_rise_s;
  logic       auto_wrap_s;

  assign press_s      = stable_q & ~stable_prev_q;
  assign any_press_s  = |press_s;
  assign vsync_rise_s = i_vid_vsync & ~vsync_q;
  // Auto step only fires when no manual press competes for the pending mode.
  assign auto_wrap_s  = auto_q & vsync_rise_s & (frm_q == FRM_MAX) & ~any_press_s;

  // Per-button debounce: accept a new level after DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = {CNT_W{1'b0}};
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_MAX) begin
          stable_d[i] = sync2_q[i];
          db_cnt_d[i] = {CNT_W{1'b0}};
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        db_cnt_d[i] = {CNT_W{1'b0}};
      end
    end
  end

  // Pending mode and auto enable: one action per cycle, btn[2] > btn[3] > btn[0]/btn[1] > auto.
  always_comb begin
    pending_d = pending_q;
    auto_d    = auto_q;
    if (press_s[2]) begin
      pending_d = {MODE_W{1'b0}};
    end else if (press_s[3]) begin
      auto_d = ~auto_q;
    end else if (press_s[0] && !press_s[1]) begin
      pending_d = mode_next(pending_q);
    end else if (press_s[1] && !press_s[0]) begin
      pending_d = mode_prev(pending_q);
    end else if (auto_wrap_s) begin
      pending_d = mode_next(pending_q);
    end else begin
      pending_d = pending_q;
    end
  end

  // Frame counter runs only in auto mode and restarts whenever auto is toggled.
  always_comb begin
    frm_d = frm_q;
    if (press_s[3] || !auto_q) begin
      frm_d = {FRM_W{1'b0}};
    end else if (vsync_rise_s) begin
      if (frm_q == FRM_MAX) frm_d = {FRM_W{1'b0}};
      else                  frm_d = frm_q + {{(FRM_W-1){1'b0}}, 1'b1};
    end else begin
      frm_d = frm_q;
    end
  end

  // Commit at the frame boundary; uses pending as registered before this cycle.
  always_comb begin
    mode_d = mode_q;
    if (vsync_rise_s) begin
      if (auto_wrap_s) mode_d = mode_next(pending_q);
      else             mode_d = pending_q;
    end else begin
      mode_d = mode_q;
    end
    update_d = (mode_d != mode_q);
  end

  // State registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q       <= 4'b0000;
      sync2_q       <= 4'b0000;
      stable_q      <= 4'b0000;
      stable_prev_q <= 4'b0000;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= {CNT_W{1'b0}};
      vsync_q       <= 1'b1;
      pending_q     <= {MODE_W{1'b0}};
      mode_q        <= {MODE_W{1'b0}};
      update_q      <= 1'b0;
      auto_q        <= 1'b0;
      frm_q         <= {FRM_W{1'b0}};
    end else begin
      sync1_q       <= btn;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
      vsync_q       <= i_vid_vsync;
      pending_q     <= pending_d;
      mode_q        <= mode_d;
      update_q      <= update_d;
      auto_q        <= auto_d;
      frm_q         <= frm_d;
    end
  end

  assign o_mode        = mode_q;
  assign o_mode_update = update_q;
  assign o_auto        = auto_q;
  assign o_pending     = pending_q;

endmodule

// File: tb/tb_colour_mode_ctrl.sv
module tb_colour_mode_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic       vsync = 1'b0;
  logic [2:0] o_mode;
  logic       o_mode_update;
  logic       o_auto;
  logic [2:0] o_pending;

  int checks = 0;
  int failures = 0;
  int upd_cnt = 0;

  always #5 clk = ~clk;

  colour_mode_ctrl #(
    .DEBOUNCE_CYCLES(8),
    .CNT_W(4),
    .NUM_MODES(4),
    .MODE_W(3),
    .AUTO_FRAMES(2)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .btn(btn),
    .i_vid_vsync(vsync),
    .o_mode(o_mode),
    .o_mode_update(o_mode_update),
    .o_auto(o_auto),
    .o_pending(o_pending)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    btn = 4'b0000;
    vsync = 1'b0;
    n_rst = 1'b0;
    tick(3);
    n_rst = 1'b1;
    tick(2);
  endtask

  // Hold long enough to be accepted (pending moves at edge 11), then release fully.
  task automatic press_btn(input logic [3:0] mask);
    btn = mask;
    tick(12);
    btn = 4'b0000;
    tick(14);
  endtask

  // One 200-clock frame: vsync high 10 clocks; counts update pulses.
  task automatic frame();
    upd_cnt = 0;
    vsync = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (i == 10) vsync = 1'b0;
      @(negedge clk);
      if (o_mode_update) upd_cnt++;
    end
  endtask

  task automatic test_reset();
    btn = 4'b0000;
    vsync = 1'b0;
    n_rst = 1'b0;
    tick(2);
    checks++;
    if ({o_mode, o_pending, o_auto, o_mode_update} !== 8'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 0", {o_mode, o_pending, o_auto, o_mode_update});
    end
    n_rst = 1'b1;
    tick(2);
  endtask

  task automatic test_press_latency();
    btn = 4'b0001;
    tick(10);
    checks++;
    if (o_pending !== 3'd0) begin
      failures++;
      $display("FAIL latency_edge10: got %0d expected 0", o_pending);
    end
    tick(1);
    checks++;
    if (o_pending !== 3'd1) begin
      failures++;
      $display("FAIL latency_edge11: got %0d expected 1", o_pending);
    end
    tick(9);
    btn = 4'b0000;
    tick(14);
    checks++;
    if (o_pending !== 3'd1) begin
      failures++;
      $display("FAIL held_single_step: got %0d expected 1", o_pending);
    end
    checks++;
    if (o_mode !== 3'd0) begin
      failures++;
      $display("FAIL mode_before_vsync: got %0d expected 0", o_mode);
    end
    frame();
    checks++;
    if (o_mode !== 3'd1) begin
      failures++;
      $display("FAIL mode_commit: got %0d expected 1", o_mode);
    end
    checks++;
    if (upd_cnt !== 1) begin
      failures++;
      $display("FAIL update_single_pulse: got %0d expected 1", upd_cnt);
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    btn = 4'b0001;
    tick(5);
    btn = 4'b0000;
    tick(15);
    btn = 4'b0010;
    tick(7);
    btn = 4'b0000;
    tick(15);
    frame();
    checks++;
    if (o_pending !== 3'd0) begin
      failures++;
      $display("FAIL glitch_pending: got %0d expected 0", o_pending);
    end
    checks++;
    if (o_mode !== 3'd0) begin
      failures++;
      $display("FAIL glitch_mode: got %0d expected 0", o_mode);
    end
    checks++;
    if (upd_cnt !== 0) begin
      failures++;
      $display("FAIL glitch_update: got %0d expected 0", upd_cnt);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    press_btn(4'b0010);
    checks++;
    if (o_pending !== 3'd3) begin
      failures++;
      $display("FAIL wrap_down_0_to_3: got %0d expected 3", o_pending);
    end
    press_btn(4'b0001);
    checks++;
    if (o_pending !== 3'd0) begin
      failures++;
      $display("FAIL wrap_up_3_to_0: got %0d expected 0", o_pending);
    end
    press_btn(4'b0010);
    press_btn(4'b0010);
    checks++;
    if (o_pending !== 3'd2) begin
      failures++;
      $display("FAIL two_downs: got %0d expected 2", o_pending);
    end
    frame();
    checks++;
    if (o_mode !== 3'd2) begin
      failures++;
      $display("FAIL wrap_commit: got %0d expected 2", o_mode);
    end
  endtask

  task automatic test_simultaneous();
    press_btn(4'b0011);
    checks++;
    if (o_pending !== 3'd2) begin
      failures++;
      $display("FAIL up_down_cancel: got %0d expected 2", o_pending);
    end
    press_btn(4'b0101);
    checks++;
    if (o_pending !== 3'd0) begin
      failures++;
      $display("FAIL btn2_priority: got %0d expected 0", o_pending);
    end
    frame();
    checks++;
    if (o_mode !== 3'd0) begin
      failures++;
      $display("FAIL passthrough_commit: got %0d expected 0", o_mode);
    end
  endtask

  task automatic test_auto_cycle();
    logic [2:0] exp_seq [7];
    exp_seq = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3};
    press_btn(4'b1000);
    checks++;
    if (o_auto !== 1'b1 || o_pending !== 3'd0) begin
      failures++;
      $display("FAIL auto_on: got auto=%0d pending=%0d expected auto=1 pending=0", o_auto, o_pending);
    end
    for (int f = 0; f < 7; f++) begin
      frame();
      checks++;
      if (o_mode !== exp_seq[f]) begin
        failures++;
        $display("FAIL auto_seq[%0d]: got %0d expected %0d", f, o_mode, exp_seq[f]);
      end
    end
    press_btn(4'b1000);
    checks++;
    if (o_auto !== 1'b0) begin
      failures++;
      $display("FAIL auto_off: got %0d expected 0", o_auto);
    end
    frame();
    frame();
    checks++;
    if (o_mode !== 3'd3 || upd_cnt !== 0) begin
      failures++;
      $display("FAIL auto_freeze: got mode=%0d upd=%0d expected mode=3 upd=0", o_mode, upd_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    press_btn(4'b0001);
    frame();
    vsync = 1'b1;
    tick(3);
    press_btn(4'b0001);
    checks++;
    if (o_pending !== 3'd2 || o_mode !== 3'd1) begin
      failures++;
      $display("FAIL pre_reset_state: got pending=%0d mode=%0d expected pending=2 mode=1", o_pending, o_mode);
    end
    #3;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({o_mode, o_pending, o_auto, o_mode_update} !== 8'b0) begin
      failures++;
      $display("FAIL async_reset: got %b expected 0", {o_mode, o_pending, o_auto, o_mode_update});
    end
    tick(2);
    n_rst = 1'b1;
    upd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_mode_update) upd_cnt++;
    end
    checks++;
    if (o_mode !== 3'd0 || o_pending !== 3'd0 || upd_cnt !== 0) begin
      failures++;
      $display("FAIL release_vsync_high: got mode=%0d pending=%0d upd=%0d expected 0 0 0", o_mode, o_pending, upd_cnt);
    end
    vsync = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_glitch();
    test_wrap();
    test_simultaneous();
    test_auto_cycle();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
